// File: rtl/unidade_saida_display_if.sv
// Handshake between the control unit and the output stage.
//   saidaControle  : output request from the control unit
//   dadoSaida      : register value to display (bank read port dadoLeitura1)
//   estagioSaidaUC : busy/stall back to the control unit
//   saidaConcluida : one-cycle pulse once the operator has confirmed
// master = control unit side, slave = output stage side.
interface unidade_saida_display_if;
  logic        saidaControle;
  logic [31:0] dadoSaida;
  logic        estagioSaidaUC;
  logic        saidaConcluida;

  modport master (
    output saidaControle,
    output dadoSaida,
    input  estagioSaidaUC,
    input  saidaConcluida
  );

  modport slave (
    input  saidaControle,
    input  dadoSaida,
    output estagioSaidaUC,
    output saidaConcluida
  );
endinterface

// File: rtl/unidade_saida_display.sv
// Output stage: on an output instruction, latches the register value, converts
// it to BCD one shift-add-3 step per clock, drives active-low 7-segment
// displays and stalls the control unit until the operator presses confirm.
//   clock         : system clock
//   reset         : asynchronous active-low reset
//   uc            : control-unit handshake (slave side)
//   botaoConfirma : raw operator key, active-high, asynchronous
//   displays      : DIGITOS digits, digit 0 in [6:0], gfedcba, active-low
//   displaySinal  : sign digit, active-low
// Optional build macro UNIDADE_SAIDA_SINAL_EN: value treated as two's
// complement over LARGURA bits, magnitude displayed with '-' on the sign digit.
module unidade_saida_display #(
  parameter int unsigned LARGURA = 16,
  parameter int unsigned DIGITOS = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  unidade_saida_display_if.slave uc,
  input  logic                   botaoConfirma,
  output logic [7*DIGITOS-1:0]   displays,
  output logic [6:0]             displaySinal
);

  localparam int unsigned LARGURA_BCD  = 4 * DIGITOS;
  localparam int unsigned LARGURA_CONT = $clog2(LARGURA + 1);
  localparam logic [6:0]  SEG_APAGADO  = 7'h7F;

  typedef enum logic [2:0] {
    OCIOSO,
    CONVERTE,
    CARREGA,
    EXIBE,
    LIBERA
  } estado_t;

  estado_t                 estado;
  logic [LARGURA-1:0]      registroDeslocamento;
  logic [LARGURA_BCD-1:0]  bcd;
  logic [LARGURA_CONT-1:0] contador;
  logic                    estagio;
  logic                    concluida;
  logic                    sincronizador1;
  logic                    sincronizador2;
  logic                    botaoAnterior;
  logic                    pulsoConfirma;
  logic [LARGURA-1:0]      valorCapturado;
  logic                    negativoCapturado;
  logic [LARGURA_BCD-1:0]  bcdAjustado;
  logic [7*DIGITOS-1:0]    segmentosProximos;
  logic                    unusedBcdTopo;

  assign uc.estagioSaidaUC = estagio;
  assign uc.saidaConcluida = concluida;

  // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [6:0] codificaDigito(input logic [3:0] digito);
    case (digito)
      4'd0:    codificaDigito = 7'h40;
      4'd1:    codificaDigito = 7'h79;
      4'd2:    codificaDigito = 7'h24;
      4'd3:    codificaDigito = 7'h30;
      4'd4:    codificaDigito = 7'h19;
      4'd5:    codificaDigito = 7'h12;
      4'd6:    codificaDigito = 7'h02;
      4'd7:    codificaDigito = 7'h78;
      4'd8:    codificaDigito = 7'h00;
      4'd9:    codificaDigito = 7'h10;
      default: codificaDigito = SEG_APAGADO;
    endcase
  endfunction

  // Magnitude to convert at request capture.
`ifdef UNIDADE_SAIDA_SINAL_EN
  always_comb begin
    negativoCapturado = uc.dadoSaida[LARGURA-1];
    valorCapturado    = uc.dadoSaida[LARGURA-1:0];
    if (negativoCapturado) begin
      valorCapturado = ~uc.dadoSaida[LARGURA-1:0] + LARGURA'(1);
    end
  end
`else
  assign negativoCapturado = 1'b0;
  assign valorCapturado    = uc.dadoSaida[LARGURA-1:0];
`endif

  // Bits above LARGURA are deliberately ignored.
  generate
    if (LARGURA < 32) begin : gBitsIgnorados
      logic unusedBitsAltos;
      assign unusedBitsAltos = ^uc.dadoSaida[31:LARGURA] ^ negativoCapturado;
    end
  endgenerate

  // Add-3 correction of every nibble >= 5 before the shift.
  always_comb begin
    bcdAjustado = bcd;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcdAjustado[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // The MSB shifted out of the BCD field is always zero for legal parameters.
  assign unusedBcdTopo = bcdAjustado[LARGURA_BCD-1];

  // Segment image with leading-zero blanking; digit 0 always shown.
  always_comb begin
    logic zerosAEsquerda;
    segmentosProximos = '1;
    zerosAEsquerda    = 1'b1;
    for (int i = int'(DIGITOS) - 1; i >= 0; i--) begin
      if (i == 0 || !zerosAEsquerda || bcd[4*i +: 4] != 4'd0) begin
        segmentosProximos[7*i +: 7] = codificaDigito(bcd[4*i +: 4]);
        zerosAEsquerda              = 1'b0;
      end
    end
  end

  // Two-flop synchronizer plus rising-edge detect on the confirm key.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sincronizador1 <= 1'b0;
      sincronizador2 <= 1'b0;
      botaoAnterior  <= 1'b0;
    end else begin
      sincronizador1 <= botaoConfirma;
      sincronizador2 <= sincronizador1;
      botaoAnterior  <= sincronizador2;
    end
  end

  assign pulsoConfirma = sincronizador2 & ~botaoAnterior;

`ifdef UNIDADE_SAIDA_SINAL_EN
  logic negativo;
  logic [6:0] sinalReg;
  assign displaySinal = sinalReg;
`else
  assign displaySinal = SEG_APAGADO;
`endif

  // Control FSM with conversion datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado               <= OCIOSO;
      estagio              <= 1'b0;
      concluida            <= 1'b0;
      registroDeslocamento <= '0;
      bcd                  <= '0;
      contador             <= '0;
      displays             <= '1;
`ifdef UNIDADE_SAIDA_SINAL_EN
      negativo             <= 1'b0;
      sinalReg             <= SEG_APAGADO;
`endif
    end else begin
      case (estado)
        OCIOSO: begin
          if (uc.saidaControle) begin
            registroDeslocamento <= valorCapturado;
            bcd                  <= '0;
            contador             <= '0;
            estagio              <= 1'b1;
`ifdef UNIDADE_SAIDA_SINAL_EN
            negativo             <= negativoCapturado;
`endif
            estado               <= CONVERTE;
          end
        end
        CONVERTE: begin
          bcd                  <= {bcdAjustado[LARGURA_BCD-2:0],
                                   registroDeslocamento[LARGURA-1]};
          registroDeslocamento <= {registroDeslocamento[LARGURA-2:0], 1'b0};
          contador             <= contador + LARGURA_CONT'(1);
          if (contador == LARGURA_CONT'(LARGURA - 1)) begin
            estado <= CARREGA;
          end
        end
        CARREGA: begin
          displays <= segmentosProximos;
`ifdef UNIDADE_SAIDA_SINAL_EN
          sinalReg <= negativo ? 7'b0111111 : SEG_APAGADO;
`endif
          estado   <= EXIBE;
        end
        EXIBE: begin
          if (pulsoConfirma) begin
            concluida <= 1'b1;
            estado    <= LIBERA;
          end
        end
        LIBERA: begin
          concluida <= 1'b0;
          estagio   <= 1'b0;
          estado    <= OCIOSO;
        end
        default: begin
          concluida <= 1'b0;
          estagio   <= 1'b0;
          estado    <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_saida_display.sv
// Self-checking bench for unidade_saida_display: table of known values,
// hand-written multi-cycle corner cases and random values against a
// decimal-arithmetic reference model.
module tb_unidade_saida_display;

  localparam int unsigned LARGURA = 16;
  localparam int unsigned DIGITOS = 5;
  localparam int unsigned LD      = 7 * DIGITOS;
  localparam logic [6:0]  BLK     = 7'h7F;
  localparam logic [6:0]  MENOS   = 7'b0111111;
  localparam logic [6:0]  SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic          clock = 1'b0;
  logic          reset;
  logic          botaoConfirma;
  logic [LD-1:0] displays;
  logic [6:0]    displaySinal;

  unidade_saida_display_if bus ();

  unidade_saida_display #(
    .LARGURA (LARGURA),
    .DIGITOS (DIGITOS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .uc            (bus),
    .botaoConfirma (botaoConfirma),
    .displays      (displays),
    .displaySinal  (displaySinal)
  );

  always #5 clock = ~clock;

  int testes = 0;
  int falhas = 0;

  typedef struct {
    logic [31:0]   dado;
    logic [LD-1:0] expDisplays;
    logic [6:0]    expSinal;
  } vetor_t;

  vetor_t tabela [8];

  task automatic verifica(input string nome, input logic [63:0] obtido,
                          input logic [63:0] esperado);
    testes++;
    if (obtido !== esperado) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, obtido, esperado, $time);
    end
  endtask

  task automatic ciclo(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reference model: value as the operator should read it.
  function automatic logic modeloNegativo(input logic [31:0] dado);
    longint modulo = longint'(1) << LARGURA;
    longint v = longint'(dado) % modulo;
`ifdef UNIDADE_SAIDA_SINAL_EN
    return v >= modulo / 2;
`else
    return (v < 0);
`endif
  endfunction

  function automatic logic [LD-1:0] modeloDisplays(input logic [31:0] dado);
    longint modulo = longint'(1) << LARGURA;
    longint m = longint'(dado) % modulo;
    int dig [DIGITOS];
    int topo = 0;
    logic [LD-1:0] r;
    if (modeloNegativo(dado)) m = modulo - m;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      dig[i] = int'(m % 10);
      m = m / 10;
      if (dig[i] != 0) topo = i;
    end
    for (int i = 0; i < int'(DIGITOS); i++) begin
      r[7*i +: 7] = (i <= topo) ? SEG[dig[i]] : BLK;
    end
    return r;
  endfunction

  // Press confirm and measure cycles until saidaConcluida; leaves the bench in LIBERA.
  task automatic pressiona(input string nome);
    int espera = 0;
    botaoConfirma = 1'b1;
    while (bus.saidaConcluida !== 1'b1 && espera < 20) begin
      ciclo(1);
      espera++;
    end
    verifica({nome, "_press_latency"}, 64'(espera), 64'd3);
    verifica({nome, "_busy_in_libera"}, 64'(bus.estagioSaidaUC), 64'd1);
    ciclo(1);
    verifica({nome, "_pulse_and_release"}, {62'd0, bus.saidaConcluida, bus.estagioSaidaUC}, 64'd0);
    botaoConfirma = 1'b0;
  endtask

  // Full output instruction from request to release.
  task automatic transacao(input string nome, input logic [31:0] dado,
                           input logic [LD-1:0] expD, input logic [6:0] expS);
    logic [LD-1:0] anterior;
    anterior = displays;
    bus.saidaControle = 1'b1;
    bus.dadoSaida     = dado;
    ciclo(1);
    bus.saidaControle = 1'b0;
    bus.dadoSaida     = $urandom();
    verifica({nome, "_busy"}, 64'(bus.estagioSaidaUC), 64'd1);
    ciclo(LARGURA);
    verifica({nome, "_hold_before_load"}, 64'(displays), 64'(anterior));
    ciclo(1);
    verifica({nome, "_displays"}, 64'(displays), 64'(expD));
    verifica({nome, "_sinal"}, 64'(displaySinal), 64'(expS));
    ciclo(4);
    verifica({nome, "_waits_press"}, {62'd0, bus.estagioSaidaUC, bus.saidaConcluida}, 64'd2);
    pressiona(nome);
    verifica({nome, "_persist"}, 64'(displays), 64'(expD));
    ciclo(3);
  endtask

  initial begin
    int altos;
    logic [31:0] r;

    tabela[0] = '{32'h0000_3039, {SEG[1], SEG[2], SEG[3], SEG[4], SEG[5]}, BLK};
    tabela[1] = '{32'hFFFF_0007, {BLK, BLK, BLK, BLK, SEG[7]}, BLK};
    tabela[2] = '{32'h0000_0000, {BLK, BLK, BLK, BLK, SEG[0]}, BLK};
    tabela[3] = '{32'h0000_0064, {BLK, BLK, SEG[1], SEG[0], SEG[0]}, BLK};
    tabela[4] = '{32'h0000_270F, {BLK, SEG[9], SEG[9], SEG[9], SEG[9]}, BLK};
    tabela[5] = '{32'h0000_7FFF, {SEG[3], SEG[2], SEG[7], SEG[6], SEG[7]}, BLK};
`ifdef UNIDADE_SAIDA_SINAL_EN
    tabela[6] = '{32'h0000_FFFF, {BLK, BLK, BLK, BLK, SEG[1]}, MENOS};
    tabela[7] = '{32'h0000_8000, {SEG[3], SEG[2], SEG[7], SEG[6], SEG[8]}, MENOS};
`else
    tabela[6] = '{32'h0000_FFFF, {SEG[6], SEG[5], SEG[5], SEG[3], SEG[5]}, BLK};
    tabela[7] = '{32'h0000_8000, {SEG[3], SEG[2], SEG[7], SEG[6], SEG[8]}, BLK};
`endif

    reset             = 1'b0;
    botaoConfirma     = 1'b0;
    bus.saidaControle = 1'b0;
    bus.dadoSaida     = '0;
    ciclo(2);
    verifica("rst_displays", 64'(displays), {{(64-LD){1'b0}}, {LD{1'b1}}});
    verifica("rst_sinal", 64'(displaySinal), 64'h7F);
    reset = 1'b1;
    ciclo(2);
    verifica("rst_outputs", {62'd0, bus.estagioSaidaUC, bus.saidaConcluida}, 64'd0);
    verifica("rst_displays_after", 64'(displays), {{(64-LD){1'b0}}, {LD{1'b1}}});

    foreach (tabela[k]) begin
      transacao($sformatf("tab%0d", k), tabela[k].dado, tabela[k].expDisplays, tabela[k].expSinal);
    end

    // Second request and key press during CONVERTE are ignored.
    bus.saidaControle = 1'b1;
    bus.dadoSaida     = 32'd4321;
    ciclo(1);
    bus.saidaControle = 1'b0;
    ciclo(3);
    bus.saidaControle = 1'b1;
    bus.dadoSaida     = 32'd9;
    botaoConfirma     = 1'b1;
    ciclo(2);
    bus.saidaControle = 1'b0;
    botaoConfirma     = 1'b0;
    ciclo(LARGURA - 4);
    verifica("ign_displays", 64'(displays), 64'(modeloDisplays(32'd4321)));
    ciclo(8);
    verifica("ign_still_waiting", {62'd0, bus.estagioSaidaUC, bus.saidaConcluida}, 64'd2);
    pressiona("ign");
    ciclo(3);
    verifica("ign_not_queued", 64'(bus.estagioSaidaUC), 64'd0);

    // Request held high across LIBERA is captured again right away.
    bus.saidaControle = 1'b1;
    bus.dadoSaida     = 32'd55;
    ciclo(LARGURA + 2);
    verifica("held_displays", 64'(displays), 64'(modeloDisplays(32'd55)));
    pressiona("held");
    ciclo(1);
    verifica("held_recaptured", 64'(bus.estagioSaidaUC), 64'd1);
    bus.saidaControle = 1'b0;
    ciclo(LARGURA + 2);
    pressiona("held2");
    ciclo(2);

    // Reset during CONVERTE aborts without a completion pulse.
    bus.saidaControle = 1'b1;
    bus.dadoSaida     = 32'd777;
    ciclo(1);
    bus.saidaControle = 1'b0;
    ciclo(5);
    reset = 1'b0;
    #1;
    verifica("abort_displays", 64'(displays), {{(64-LD){1'b0}}, {LD{1'b1}}});
    verifica("abort_outputs", {62'd0, bus.estagioSaidaUC, bus.saidaConcluida}, 64'd0);
    ciclo(2);
    reset = 1'b1;
    altos = 0;
    for (int i = 0; i < 25; i++) begin
      ciclo(1);
      if (bus.saidaConcluida !== 1'b0 || bus.estagioSaidaUC !== 1'b0) altos++;
    end
    verifica("abort_quiet", 64'(altos), 64'd0);

    // Random values against the reference model.
    for (int i = 0; i < 10; i++) begin
      r = $urandom();
      transacao($sformatf("rnd%0d", i), r, modeloDisplays(r),
                modeloNegativo(r) ? MENOS : BLK);
    end

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule

// File: doc/unidade_saida_display.md
Name: unidade_saida_display

Overview:
- Output-side counterpart of the switch/register-bank input stage.
- When the control unit executes an output instruction, the block latches the register value and converts it to BCD sequentially (shift-add-3).
- It drives active-low 7-segment displays and stalls the control unit until the operator presses the confirm button.
- Sits between the register bank read port (dadoLeitura1) and the board displays/keys.

Parameters:
- LARGURA, 16, number of low bits of dadoSaida converted; legal range 4..32.
- DIGITOS, 5, number of decimal display digits; must be >= ceil(LARGURA*0.30103).

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- saidaControle  input  1  output request from control unit; sampled only in OCIOSO.
- dadoSaida  input  32  value to display; only bits [LARGURA-1:0] are used.
- botaoConfirma  input  1  raw operator key, active-high, asynchronous to clock.
- estagioSaidaUC  output  1  busy/stall to control unit; high from request capture until release.
- saidaConcluida  output  1  one-cycle pulse when the operator has confirmed.
- displays  output  7*DIGITOS  segments, digit 0 in [6:0]; bit order gfedcba, active-low.
- displaySinal  output  7  sign digit, active-low.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=OCIOSO; estagioSaidaUC=0; saidaConcluida=0.
  - displays all 1s (blank); displaySinal=7'h7F.
  - Shift/BCD registers and counter cleared; synchronizer flops cleared.
- botaoConfirma handling: 2-flop synchronizer, then rising-edge detect (prev=0, now=1) gives a one-cycle press pulse. Presses outside EXIBE are discarded, never queued.
- States and transitions:
  - OCIOSO: if saidaControle=1 at edge N, latch dadoSaida[LARGURA-1:0], clear BCD and counter, set estagioSaidaUC=1 and go to CONVERTE. Otherwise stay.
  - CONVERTE: one shift-add-3 step per edge, LARGURA steps at edges N+1..N+LARGURA.
    - Per step: each BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1.
    - After step LARGURA, go to CARREGA.
  - CARREGA (edge N+LARGURA+1): load display registers from BCD, then go to EXIBE.
    - Digit encoding: 0..9 as standard active-low patterns.
    - Leading-zero blanking: all-zero high digits are blank; digit 0 is always shown (value 0 shows "0").
  - EXIBE: hold displays until a synchronized press pulse, then go to LIBERA.
  - LIBERA: saidaConcluida=1 for exactly this cycle; estagioSaidaUC=0 on the edge leaving LIBERA; go to OCIOSO.
- Busy: estagioSaidaUC is 1 in CONVERTE, CARREGA, EXIBE and LIBERA.
- Requests: saidaControle while busy is ignored. A request held high across LIBERA is captured again in the first OCIOSO cycle (the control unit must drop it on saidaConcluida).
- Display persistence: displays keep the last value after release until the next CARREGA; they change only in CARREGA or reset.
- Latency: request edge to new display is LARGURA+1 edges; minimum request-to-release is LARGURA+2+press latency (>=3 edges of sync+detect).
- Reset mid-operation: aborts immediately to the reset values. No pulse on saidaConcluida; a pending press is lost.
- Values >= 10^DIGITOS cannot occur for legal parameters; no saturation logic.

Optional Feature:
- Macro: UNIDADE_SAIDA_SINAL_EN.
- With the macro:
  - The latched value is two's complement over LARGURA bits.
  - If the MSB is 1, the magnitude (negated value) is converted and displaySinal shows '-' (7'b0111111) from CARREGA.
  - Otherwise displaySinal is blank.
  - -2^(LARGURA-1) converts correctly as an unsigned magnitude.
- Without the macro:
  - Value is unsigned.
  - displaySinal is constant 7'h7F.

Test Plan:
- Reset while idle, then release -> displays all 1s, displaySinal=7'h7F, estagioSaidaUC=0, saidaConcluida=0.
- saidaControle=1 with dadoSaida=32'h0000_3039 (12345), defaults -> estagioSaidaUC=1 after edge N; at edge N+17 the digits show 1,2,3,4,5; no release before a press.
- Press botaoConfirma in EXIBE -> saidaConcluida pulses exactly 1 cycle, estagioSaidaUC falls on the next edge, displays still show 12345.
- dadoSaida=32'hFFFF_0007 -> upper bits ignored; digit 0 shows "7", digits 1..4 blank. dadoSaida=0 shows a single "0".
- Second request and button presses during CONVERTE -> both ignored; the in-flight value completes, and EXIBE still waits for a new press. Reset asserted during CONVERTE -> immediate blank, no saidaConcluida.
- With UNIDADE_SAIDA_SINAL_EN: dadoSaida=32'h0000_FFFF -> displays "1" and displaySinal=7'b0111111; 32'h0000_8000 -> "32768" with '-'.
